// File: rtl/nibble_frame_tx.sv
// Nibble FIFO feeding a 4-cycle framed output toward a slow-clock receiver.
// Optional even parity on data_out when NIBBLE_TX_PARITY_EN is defined.
module nibble_frame_tx #(
    parameter int unsigned DEPTH       = 4,
    parameter logic [3:0]  IDLE_NIBBLE = 4'h0
) (
    input  logic       fast_clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic [3:0] data_out,
    output logic       tx_valid,
    output logic       sync_out,
    output logic       slow_clk_out,
    output logic       tx_parity,
    output logic [7:0] frame_cnt,
    output logic [7:0] underrun_cnt
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [1:0]    div_q, div_d;
    logic          sync_q, sync_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic [7:0]    frame_q, frame_d;
    logic [7:0]    under_q, under_d;
    logic          seen_q, seen_d;

    logic load, full, empty, push, pop;

    assign load  = (div_q == 2'd3);
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign push  = in_valid && !full;
    // pop uses registered occupancy, so a nibble pushed on a load edge waits a frame
    assign pop   = load && !empty;

    always_comb begin
        div_d    = div_q + 2'd1;
        sync_d   = (div_q == 2'd2);
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CNT_ONE;
        if (!push && pop) count_d = count_q - CNT_ONE;
        data_d  = data_q;
        valid_d = valid_q;
        frame_d = frame_q;
        under_d = under_q;
        seen_d  = seen_q;
        if (load) begin
            if (!empty) begin
                data_d  = mem_q[rd_ptr_q];
                valid_d = 1'b1;
                frame_d = frame_q + 8'd1;
                seen_d  = 1'b1;
            end else begin
                data_d  = IDLE_NIBBLE;
                valid_d = 1'b0;
                if (seen_q && under_q != 8'hFF) under_d = under_q + 8'd1;
            end
        end
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            sync_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= IDLE_NIBBLE;
            valid_q  <= 1'b0;
            frame_q  <= '0;
            under_q  <= '0;
            seen_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            sync_q   <= sync_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            frame_q  <= frame_d;
            under_q  <= under_d;
            seen_q   <= seen_d;
        end
    end

    always_ff @(posedge fast_clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef NIBBLE_TX_PARITY_EN
    logic parity_q;
    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n)    parity_q <= ^IDLE_NIBBLE;
        else if (load) parity_q <= ^data_d;
    end
    assign tx_parity = parity_q;
`else
    assign tx_parity = 1'b0;
`endif

    assign in_ready     = !full;
    assign data_out     = data_q;
    assign tx_valid     = valid_q;
    assign sync_out     = sync_q;
    assign slow_clk_out = div_q[0];
    assign frame_cnt    = frame_q;
    assign underrun_cnt = under_q;

endmodule

// File: tb/tb_nibble_frame_tx.sv
// Directed bench for nibble_frame_tx: framing, FIFO order/backpressure,
// no-bypass timing, underrun counting, parity and mid-frame reset.
module tb_nibble_frame_tx;

    logic       fast_clk = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data  = 4'h0;
    logic       in_ready;
    logic [3:0] data_out;
    logic       tx_valid;
    logic       sync_out;
    logic       slow_clk_out;
    logic       tx_parity;
    logic [7:0] frame_cnt;
    logic [7:0] underrun_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int          n = 0;

    nibble_frame_tx #(.DEPTH(4), .IDLE_NIBBLE(4'h0)) dut (
        .fast_clk     (fast_clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .data_out     (data_out),
        .tx_valid     (tx_valid),
        .sync_out     (sync_out),
        .slow_clk_out (slow_clk_out),
        .tx_parity    (tx_parity),
        .frame_cnt    (frame_cnt),
        .underrun_cnt (underrun_cnt)
    );

    always #5 fast_clk = ~fast_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic tick();
        @(posedge fast_clk);
        @(negedge fast_clk);
        n++;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_data"},   data_out, 4'h0);
        check_eq({tag, "_valid"},  tx_valid, 1'b0);
        check_eq({tag, "_sync"},   sync_out, 1'b0);
        check_eq({tag, "_slow"},   slow_clk_out, 1'b0);
        check_eq({tag, "_ready"},  in_ready, 1'b1);
        check_eq({tag, "_parity"}, tx_parity, 1'b0);
        check_eq({tag, "_frames"}, frame_cnt, 8'd0);
        check_eq({tag, "_under"},  underrun_cnt, 8'd0);
    endtask

    logic [3:0] recv[$];
    int         idx;
    logic       acc;
    logic       par_b, par_3, par_7;

    initial begin
`ifdef NIBBLE_TX_PARITY_EN
        par_b = 1'b1; par_3 = 1'b0; par_7 = 1'b1;
`else
        par_b = 1'b0; par_3 = 1'b0; par_7 = 1'b0;
`endif
        // reset held across a clock edge
        #12;
        check_reset_values("rst");
        @(negedge fast_clk);
        rst_n = 1'b1;
        n = 0;

        // idle framing: sync on edges 3,7,11 (cycles 4,8,12)
        repeat (12) begin
            tick();
            check_eq("idle_sync", sync_out, (n % 4) == 3);
            check_eq("idle_slow", slow_clk_out, (n % 2) == 1);
        end
        check_eq("idle_data", data_out, 4'h0);
        check_eq("idle_valid", tx_valid, 1'b0);
        check_eq("idle_under", underrun_cnt, 8'd0);

        // A,5,F back to back, then underrun
        in_valid = 1'b1; in_data = 4'hA; tick();
        in_data = 4'h5; tick();
        in_data = 4'hF; tick();
        in_valid = 1'b0; tick();                 // n=16, load
        check_eq("f1_data", data_out, 4'hA);
        check_eq("f1_valid", tx_valid, 1'b1);
        check_eq("f1_par", tx_parity, 1'b0);
        check_eq("f1_frames", frame_cnt, 8'd1);
        repeat (4) tick();                        // n=20
        check_eq("f2_data", data_out, 4'h5);
        check_eq("f2_valid", tx_valid, 1'b1);
        repeat (4) tick();                        // n=24
        check_eq("f3_data", data_out, 4'hF);
        check_eq("f3_frames", frame_cnt, 8'd3);
        repeat (4) tick();                        // n=28
        check_eq("f4_valid", tx_valid, 1'b0);
        check_eq("f4_data", data_out, 4'h0);
        check_eq("f4_under", underrun_cnt, 8'd1);

        // 1..6 into DEPTH=4, first push on a load edge
        repeat (3) tick();                        // n=31
        idx = 0;
        for (int c = 0; c < 28; c++) begin
            in_valid = (idx < 6);
            in_data  = 4'(idx + 1);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx == 4) check_eq("full_after_4", in_ready, 1'b0);
            end
            if ((n % 4) == 0 && tx_valid) recv.push_back(data_out);
        end
        in_valid = 1'b0;                          // n=59
        check_eq("burst_pushed", idx, 6);
        check_eq("burst_count", recv.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < recv.size()) check_eq("burst_order", recv[i], 4'(i + 1));
        end
        check_eq("burst_frames", frame_cnt, 8'd9);
        check_eq("burst_under", underrun_cnt, 8'd2);

        // push on load edge into empty FIFO: no bypass
        in_valid = 1'b1; in_data = 4'h7; tick(); // n=60
        in_valid = 1'b0;
        check_eq("nobyp_valid", tx_valid, 1'b0);
        check_eq("nobyp_data", data_out, 4'h0);
        check_eq("nobyp_under", underrun_cnt, 8'd3);
        repeat (4) tick();                        // n=64
        check_eq("nobyp7_data", data_out, 4'h7);
        check_eq("nobyp7_valid", tx_valid, 1'b1);
        check_eq("nobyp7_par", tx_parity, par_7);
        check_eq("nobyp7_frames", frame_cnt, 8'd10);

        // parity of B then 3
        in_valid = 1'b1; in_data = 4'hB; tick(); // n=65
        in_data = 4'h3; tick();
        in_valid = 1'b0;
        repeat (2) tick();                        // n=68
        check_eq("parB_data", data_out, 4'hB);
        check_eq("parB_par", tx_parity, par_b);
        repeat (4) tick();                        // n=72
        check_eq("par3_data", data_out, 4'h3);
        check_eq("par3_par", tx_parity, par_3);
        check_eq("par3_frames", frame_cnt, 8'd12);

        // mid-frame reset with 3 nibbles queued at div_cnt=2
        repeat (2) tick();                        // n=74
        in_valid = 1'b1; in_data = 4'h9; tick(); // n=75
        in_data = 4'h1; tick();                   // n=76, 9 loaded
        in_data = 4'h2; tick();
        in_data = 4'h3; tick();                   // n=78, div=2
        in_valid = 1'b0;
        check_eq("pre_rst_data", data_out, 4'h9);
        check_eq("pre_rst_ready", in_ready, 1'b1);
        check_eq("pre_rst_frames", frame_cnt, 8'd13);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge fast_clk);
        @(negedge fast_clk);
        check_reset_values("midrst_hold");
        rst_n = 1'b1;
        n = 0;
        repeat (16) begin
            tick();
            check_eq("post_sync", sync_out, (n % 4) == 3);
            if ((n % 4) == 0) begin
                check_eq("post_valid", tx_valid, 1'b0);
                check_eq("post_data", data_out, 4'h0);
            end
        end
        check_eq("post_frames", frame_cnt, 8'd0);
        check_eq("post_under", underrun_cnt, 8'd0);
        check_eq("post_ready", in_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/nibble_frame_tx.md
NIBBLE_FRAME_TX -- requirements
Module: nibble_frame_tx

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in nibbles; power of two, at least 2.
REQ-002 Parameter IDLE_NIBBLE, default 4'h0, value driven on data_out when no frame is valid.
REQ-003 fast_clk  in  1  single clock; all state on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  producer offers in_data.
REQ-006 in_data  in  4  nibble to transmit.
REQ-007 in_ready  out  1  FIFO can accept a nibble.
REQ-008 data_out  out  4  framed nibble toward the sync receiver, held for a whole frame.
REQ-009 tx_valid  out  1  data_out carries FIFO data, not idle fill.
REQ-010 sync_out  out  1  frame-sample strobe, high in the last cycle of each frame.
REQ-011 slow_clk_out  out  1  divided clock, equal to div_cnt[0].
REQ-012 tx_parity  out  1  even parity of data_out (see Configuration).
REQ-013 frame_cnt  out  8  count of valid frames sent.
REQ-014 underrun_cnt  out  8  count of idle frames sent after the first valid frame.

Function
REQ-015 A 2-bit div_cnt SHALL count 0,1,2,3,0,... on every fast_clk edge; a frame is the four cycles div_cnt=0..3.
REQ-016 sync_out SHALL be 1 exactly when div_cnt==3, registered-decode only, no glitch path from inputs.
REQ-017 The load edge is the edge where div_cnt==3; data_out, tx_valid and tx_parity SHALL change only on load edges.
REQ-018 On a load edge with the FIFO non-empty: pop the head; data_out <= head; tx_valid <= 1; frame_cnt += 1, wrapping 255->0.
REQ-019 On a load edge with the FIFO empty: data_out <= IDLE_NIBBLE; tx_valid <= 0.
REQ-020 underrun_cnt SHALL increment on an empty load edge only if frame_cnt has ever been non-zero since reset; it saturates at 255.
REQ-021 in_ready SHALL be !full, derived from registered occupancy; push occurs when in_valid && in_ready.
REQ-022 Push and pop on the same edge SHALL both take effect; occupancy unchanged.
REQ-023 No bypass: a nibble pushed on a load edge into an empty FIFO SHALL be sent at the next load edge, not the current one.
REQ-024 When full, in_ready=0 even if a pop occurs that edge; in_data is ignored.
REQ-025 FIFO order SHALL be strict first-in-first-out; pointers wrap modulo DEPTH; occupancy ranges 0..DEPTH.
REQ-026 in_valid with in_ready=0 SHALL not alter any state.

Reset
REQ-027 While rst_n=0, regardless of clock: div_cnt=0, FIFO empty, data_out=IDLE_NIBBLE, tx_valid=0, sync_out=0, slow_clk_out=0, in_ready=1, tx_parity=parity(IDLE_NIBBLE) or 0 per Configuration, frame_cnt=0, underrun_cnt=0.
REQ-028 Reset asserted mid-frame SHALL discard FIFO contents and the frame in flight; after deassertion the first load edge is the fourth rising edge.

Configuration
REQ-029 Macro NIBBLE_TX_PARITY_EN defined: tx_parity is registered on load edges as XOR of the new data_out bits.
REQ-030 Macro NIBBLE_TX_PARITY_EN undefined: tx_parity is constant 0 and no parity logic is built; all other behaviour is identical.

Verification
REQ-031 Reset release, in_valid=0 for 12 cycles -> sync_out high in cycles 4,8,12; data_out=4'h0, tx_valid=0, underrun_cnt=0.
REQ-032 Push 4'hA, 4'h5, 4'hF back-to-back -> three consecutive frames carry A, 5, F with tx_valid=1; frame_cnt=3; the next frame is idle; underrun_cnt=1.
REQ-033 Push 6 nibbles 1..6 with no gap, DEPTH=4 -> in_ready falls after the 4th push and nibbles 5,6 are accepted only as pops free space; output order is 1..6, none lost or duplicated.
REQ-034 Push 4'h7 exactly on a load edge into an empty FIFO -> that frame is idle; 7 appears in the following frame.
REQ-035 Assert rst_n=0 at div_cnt=2 with 3 nibbles queued -> all outputs return to reset values immediately; after release no queued nibble is ever sent.
REQ-036 With NIBBLE_TX_PARITY_EN, send 4'hB then 4'h3 -> tx_parity 1 then 0; without the macro, tx_parity stays 0.
